// File: rtl/mem_access_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_seq : single-transaction memory/IO bridge sequencer (read/write)
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_access_seq #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Rw,
  input  logic [15:0] Addr_in,
  input  logic [15:0] Wdata,
  input  logic [15:0] Data_to_CPU,
  output logic [15:0] ADDR,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_from_CPU,
  output logic [15:0] Rdata,
  output logic        Done,
  output logic        Busy
);

  // A zero wait-state setting still needs one OE cycle to sample the bridge.
  localparam int EFF_WS = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam int CNT_W  = (EFF_WS > 1) ? $clog2(EFF_WS) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(EFF_WS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [15:0]      r_rdata;
  logic             w_accept;
  logic             w_capture;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = Rw ? S_WR_SETUP : S_READ;
        end
      end
      S_READ: begin
        if (r_cnt == c_CNT_LAST) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WR_SETUP: w_state_nxt = S_WR_PULSE;
      S_WR_PULSE: w_state_nxt = S_WR_HOLD;
      S_WR_HOLD:  w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= Addr_in;
        r_wdata <= Wdata;
      end
      if (w_capture) begin
        r_rdata <= Data_to_CPU;
      end
    end
  end

  // Strobes decode straight from state so reset removes them without a clock.
  assign OE            = (r_state == S_READ);
  assign WE            = (r_state == S_WR_PULSE);
  assign Done          = (r_state == S_DONE);
  assign Busy          = (r_state != S_IDLE);
  assign ADDR          = r_addr;
  assign Data_from_CPU = r_wdata;
  assign Rdata         = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// tb_mem_access_seq : scoreboard bench for mem_access_seq (read/write timing,
// held request, asynchronous reset abort).
module tb_mem_access_seq;

  localparam int WS = 2;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        Rw;
  logic [15:0] Addr_in;
  logic [15:0] Wdata;
  logic [15:0] Data_to_CPU;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_from_CPU;
  logic [15:0] Rdata;
  logic        Done;
  logic        Busy;

  mem_access_seq #(.WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Rw(Rw), .Addr_in(Addr_in),
    .Wdata(Wdata), .Data_to_CPU(Data_to_CPU), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_from_CPU(Data_from_CPU), .Rdata(Rdata), .Done(Done), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_rdata = 16'h0000;
  int          done_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic rw, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] dcpu);
    exp_t e;
    e.rw = rw; e.addr = addr; e.wdata = wdata;
    if (!rw) model_rdata = dcpu;
    e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  // Monitor: measures each transaction from the first busy cycle to Done.
  logic prev_busy = 1'b0;
  logic active    = 1'b0;
  int   lat, oe_n, we_n, we_at;

  always @(negedge Clk) begin
    if (Reset) begin
      prev_busy = 1'b0;
      active    = 1'b0;
    end else begin
      check_val("oe_we_excl", {63'd0, OE & WE}, 64'd0);
      if (!Busy) check_val("idle_strobes", {61'd0, OE, WE, Done}, 64'd0);
      if (Busy && !prev_busy) begin
        active = 1'b1; lat = 1; oe_n = 0; we_n = 0; we_at = 0;
      end else if (active) begin
        lat++;
      end
      if (active) begin
        if (OE) oe_n++;
        if (WE) begin we_n++; we_at = lat; end
      end
      if (Done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check_val("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("addr", ADDR, e.addr);
          check_val("rdata", Rdata, e.rdata);
          check_val("done_latency", lat, e.rw ? 4 : WS + 1);
          check_val("oe_cycles", oe_n, e.rw ? 0 : WS);
          check_val("we_cycles", we_n, e.rw ? 1 : 0);
          if (e.rw) begin
            check_val("we_cycle", we_at, 2);
            check_val("wdata_out", Data_from_CPU, e.wdata);
          end
        end
        active = 1'b0;
      end
      prev_busy = Busy;
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge Clk);
    check_val("drain_timeout", sb.size(), 0);
    @(negedge Clk);
  endtask

  // Issues one request from IDLE; inputs are scrambled after acceptance.
  task automatic do_txn(input logic rw, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] dcpu);
    Req = 1'b1; Rw = rw; Addr_in = addr; Wdata = wdata; Data_to_CPU = dcpu;
    push_exp(rw, addr, wdata, dcpu);
    @(negedge Clk);
    Req = 1'b0; Rw = ~rw; Addr_in = ~addr; Wdata = ~wdata;
    drain();
  endtask

  int next_acc;
  int done_before;

  initial begin
    Reset = 1'b1; Req = 1'b0; Rw = 1'b0; Addr_in = '0; Wdata = '0; Data_to_CPU = '0;
    #1;
    check_val("reset_outputs", {ADDR, Data_from_CPU, Rdata, OE, WE, Done, Busy}, 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    do_txn(1'b0, 16'h1234, 16'h0000, 16'hBEEF);
    do_txn(1'b1, 16'hFFFF, 16'h00A5, 16'h0000);
    do_txn(1'b0, 16'hFFFF, 16'h0000, 16'h03FF);
    do_txn(1'b1, 16'h0001, 16'h1111, 16'h7777);
    check_val("rdata_hold_after_write", Rdata, 16'h03FF);

    // Reset in mid-idle, between clock edges.
    #2 Reset = 1'b1;
    #1 check_val("async_reset_idle", {ADDR, Data_from_CPU, Rdata, OE, WE, Done, Busy}, 64'd0);
    model_rdata = 16'h0000;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_val("busy_after_reset", Busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Req held high with Rw toggling every cycle.
    Data_to_CPU = 16'h5A5A;
    Req = 1'b1;
    next_acc = 0;
    for (int c = 0; c < 40; c++) begin
      Rw = c[0]; Addr_in = 16'h4000 + 16'(c); Wdata = 16'h9000 + 16'(c);
      if (c == next_acc) begin
        push_exp(Rw, Addr_in, Wdata, Data_to_CPU);
        next_acc = c + (Rw ? 5 : WS + 2);
      end
      @(negedge Clk);
    end
    Req = 1'b0;
    drain();

    // Reset during WR_PULSE aborts the write without a Done pulse.
    Req = 1'b1; Rw = 1'b1; Addr_in = 16'hCAFE; Wdata = 16'h5555;
    @(negedge Clk);
    Req = 1'b0;
    for (int i = 0; i < 10 && !WE; i++) @(negedge Clk);
    check_val("we_reached", WE, 1'b1);
    done_before = done_cnt;
    #2 Reset = 1'b1;
    #1 check_val("we_async_drop", {WE, Busy, Done}, 3'b000);
    model_rdata = 16'h0000;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check_val("no_done_after_abort", done_cnt, done_before);
    check_val("idle_after_abort", Busy, 1'b0);

    do_txn(1'b0, 16'h0F0F, 16'h0000, 16'h1357);
    check_val("rdata_resume", Rdata, 16'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
- REQ-001: Parameter WAIT_STATES, default 2; number of cycles OE is held per read; a value of 0 SHALL be treated as 1.
- REQ-002: Clk  input  1  system clock; all state changes on rising edge.
- REQ-003: Reset  input  1  asynchronous, active-high reset.
- REQ-004: Req  input  1  datapath transaction request, sampled only in IDLE.
- REQ-005: Rw  input  1  transaction type: 0 = read, 1 = write.
- REQ-006: Addr_in  input  16  transaction address.
- REQ-007: Wdata  input  16  write data.
- REQ-008: Data_to_CPU  input  16  read data returned by the memory/IO bridge.
- REQ-009: ADDR  output  16  address driven to the bridge.
- REQ-010: OE  output  1  read enable to the bridge.
- REQ-011: WE  output  1  write enable to the bridge.
- REQ-012: Data_from_CPU  output  16  write data driven to the bridge.
- REQ-013: Rdata  output  16  captured read data.
- REQ-014: Done  output  1  single-cycle transaction-complete pulse.
- REQ-015: Busy  output  1  high in every state except IDLE.

Function
- REQ-016: States SHALL be IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
- REQ-017: In IDLE with Req=1, the block SHALL latch Addr_in, Rw and Wdata, then go to READ if Rw=0 or to WR_SETUP if Rw=1; with Req=0 it SHALL stay in IDLE.
- REQ-018: ADDR SHALL equal the latched address and Data_from_CPU the latched write data at all times; both change only on acceptance.
- REQ-019: In READ, OE=1 and WE=0 for exactly WAIT_STATES cycles, counted by an internal counter; on the last READ cycle's edge Rdata SHALL capture Data_to_CPU, then go to DONE.
- REQ-020: In WR_SETUP, OE=0 and WE=0 for one cycle; in WR_PULSE, WE=1 for exactly one cycle; in WR_HOLD, WE=0 for one cycle with address and data held; then go to DONE.
- REQ-021: DONE SHALL assert Done=1 for exactly one cycle, then return to IDLE unconditionally.
- REQ-022: Read latency: with acceptance edge at cycle t, READ occupies t+1..t+WAIT_STATES and Done is high at t+WAIT_STATES+1.
- REQ-023: Write latency: with acceptance edge at cycle t, WE is high in cycle t+2 only and Done is high at t+4.
- REQ-024: OE and WE SHALL never be 1 in the same cycle, and both SHALL be 0 in IDLE and DONE.
- REQ-025: Req in any state other than IDLE SHALL be ignored (no queuing); Req held high SHALL start the next transaction on the first IDLE cycle after DONE.
- REQ-026: Rdata SHALL hold its value until the next read completes; writes SHALL NOT modify Rdata.
- REQ-027: Changes of Addr_in, Wdata or Rw after acceptance SHALL NOT affect the transaction in flight.

Reset
- REQ-028: Reset=1 SHALL immediately, without a clock edge, force state IDLE, counter 0 and ADDR, Data_from_CPU, Rdata, OE, WE, Done and Busy to 0.
- REQ-029: Reset during any state SHALL abort the transaction with no further WE or Done pulse; operation SHALL resume from IDLE on the first edge after Reset falls.

Verification
- REQ-030: Assert Reset mid-idle without a clock -> all outputs 0 immediately; after release, Busy=0.
- REQ-031: WAIT_STATES=2, read Addr_in=0x1234, Data_to_CPU=0xBEEF -> ADDR=0x1234, OE high two cycles, Done at t+3, Rdata=0xBEEF.
- REQ-032: Write Addr_in=0xFFFF, Wdata=0x00A5 -> WE high exactly one cycle at t+2, OE stays 0, Done at t+4; downstream hex digits show 5, A, 0, 0.
- REQ-033: Read Addr_in=0xFFFF with Data_to_CPU=0x03FF (switches all on) -> Rdata=0x03FF; a following write leaves Rdata=0x03FF.
- REQ-034: Req held high with Rw alternating each cycle -> exactly one transaction per IDLE visit, no overlap, OE and WE never both high.
- REQ-035: Reset asserted during WR_PULSE -> WE falls asynchronously, no Done pulse, state IDLE after release.
